// File: rtl/pipeline_fetch_unit.sv
// Stage-1 fetch: PC ownership, credit-limited imem requests, tagged in-order responses,
// head-of-buffer presentation to decode, delay-slot-preserving jump redirect.
module pipeline_fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h0000_3000,
  parameter int          BUFFER_DEPTH    = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imemReqValid,
  input  logic        imemReqReady,
  output logic [31:0] imemReqAddr,
  input  logic        imemRespValid,
  input  logic [31:0] imemRespData,
  input  logic        stallOnDecode,
  input  logic        jumpEnabled,
  input  logic [31:0] jumpValue,
  output logic        fetchValid,
  output logic [31:0] fetchProgramCounter,
  output logic [31:0] fetchInstruction
);

  localparam int BW = $clog2(BUFFER_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {SEQ, WAIT_DELAY} state_e;

  logic [31:0]   buf_pc_q  [BUFFER_DEPTH];
  logic [31:0]   buf_pc_d  [BUFFER_DEPTH];
  logic [31:0]   buf_ins_q [BUFFER_DEPTH];
  logic [31:0]   buf_ins_d [BUFFER_DEPTH];
  logic [BW-1:0] cnt_q, cnt_d, cnt_base;
  logic [31:0]   tag_q [MAX_OUTSTANDING];
  logic [31:0]   tag_d [MAX_OUTSTANDING];
  logic [OW-1:0] out_q, out_d, out_pop;
  logic [31:0]   req_pc_q, req_pc_d;
  logic [31:0]   exp_pc_q, exp_pc_d;
  logic [31:0]   tgt_q, tgt_d;
  logic          pend_q, pend_d;
  logic [31:0]   pend_pc_q, pend_pc_d;
  state_e        state_q, state_d;

  logic        can_req, acc, held, rsp, pop, jmp;
  logic        push_ok, push_en, have_delay, delay_req, to_delay;
  logic [31:0] delay;

  assign can_req = (int'(cnt_q) + int'(out_q) < BUFFER_DEPTH)
                && (int'(out_q) < MAX_OUTSTANDING);
  assign imemReqValid = !reset && can_req;
  assign imemReqAddr  = req_pc_q;

  assign fetchValid          = (cnt_q != '0);
  assign fetchProgramCounter = buf_pc_q[0];
  assign fetchInstruction    = fetchValid ? buf_ins_q[0] : 32'h0;

  assign acc        = imemReqValid && imemReqReady;
  assign held       = imemReqValid && !imemReqReady;
  assign rsp        = imemRespValid && (out_q != '0);
  assign pop        = fetchValid && !stallOnDecode;
  assign jmp        = pop && jumpEnabled;
  assign delay      = buf_pc_q[0] + 32'd4;
  assign push_ok    = rsp && (tag_q[0] == exp_pc_q);
  assign have_delay = (int'(cnt_q) >= 2);

  always_comb begin
    delay_req = acc && (req_pc_q == delay);
    for (int i = 0; i < MAX_OUTSTANDING; i++)
      if ((OW'(i) < out_q) && (tag_q[i] == delay))
        delay_req = 1'b1;
  end

  always_comb begin
    tag_d     = tag_q;
    buf_pc_d  = buf_pc_q;
    buf_ins_d = buf_ins_q;
    req_pc_d  = req_pc_q;
    exp_pc_d  = exp_pc_q;
    tgt_d     = tgt_q;
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;
    state_d   = state_q;
    to_delay  = 1'b0;

    if (rsp)
      for (int i = 0; i < MAX_OUTSTANDING - 1; i++)
        tag_d[i] = tag_q[i+1];
    out_pop = out_q - OW'(rsp);
    for (int i = 0; i < MAX_OUTSTANDING; i++)
      if (acc && (out_pop == OW'(i)))
        tag_d[i] = req_pc_q;
    out_d = out_pop + OW'(acc);

    if (pop)
      for (int i = 0; i < BUFFER_DEPTH - 1; i++) begin
        buf_pc_d[i]  = buf_pc_q[i+1];
        buf_ins_d[i] = buf_ins_q[i+1];
      end
    if (jmp)
      cnt_base = have_delay ? BW'(1) : '0;
    else
      cnt_base = cnt_q - BW'(pop);
    // a word younger than a buffered delay slot is wrong-path
    push_en = push_ok && !(jmp && have_delay);
    for (int i = 0; i < BUFFER_DEPTH; i++)
      if (push_en && (cnt_base == BW'(i))) begin
        buf_pc_d[i]  = tag_q[0];
        buf_ins_d[i] = imemRespData;
      end
    cnt_d = cnt_base + BW'(push_en);

    if (push_ok) begin
      if (state_q == WAIT_DELAY) begin
        exp_pc_d = tgt_q;
        state_d  = SEQ;
      end else begin
        exp_pc_d = exp_pc_q + 32'd4;
      end
    end

    if (acc) begin
      if (pend_q) begin
        req_pc_d = pend_pc_q;
        pend_d   = 1'b0;
      end else begin
        req_pc_d = req_pc_q + 32'd4;
      end
    end

    if (jmp) begin
      if (have_delay || push_ok) begin
        exp_pc_d = jumpValue;
        state_d  = SEQ;
      end else begin
        exp_pc_d = delay;
        tgt_d    = jumpValue;
        state_d  = WAIT_DELAY;
        to_delay = !delay_req;
      end
      // a stalled request must keep its address; redirect after it issues
      if (held) begin
        pend_d    = 1'b1;
        pend_pc_d = jumpValue;
      end else if (to_delay) begin
        req_pc_d  = delay;
        pend_d    = 1'b1;
        pend_pc_d = jumpValue;
      end else begin
        req_pc_d = jumpValue;
        pend_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < BUFFER_DEPTH; i++) begin
        buf_pc_q[i]  <= (i == 0) ? RESET_PC : 32'h0;
        buf_ins_q[i] <= 32'h0;
      end
      for (int i = 0; i < MAX_OUTSTANDING; i++)
        tag_q[i] <= 32'h0;
      cnt_q     <= '0;
      out_q     <= '0;
      req_pc_q  <= RESET_PC;
      exp_pc_q  <= RESET_PC;
      tgt_q     <= RESET_PC;
      pend_q    <= 1'b0;
      pend_pc_q <= RESET_PC;
      state_q   <= SEQ;
    end else begin
      buf_pc_q  <= buf_pc_d;
      buf_ins_q <= buf_ins_d;
      tag_q     <= tag_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      req_pc_q  <= req_pc_d;
      exp_pc_q  <= exp_pc_d;
      tgt_q     <= tgt_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
      state_q   <= state_d;
    end
  end

  jump_needs_valid: assert property (
    @(posedge clock) disable iff (reset) jumpEnabled |-> fetchValid
  );

endmodule

// File: tb/tb_pipeline_fetch_unit.sv
// Directed bench for pipeline_fetch_unit with a latency-programmable
// in-order instruction memory model.
module tb_pipeline_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imemReqValid;
  logic        imemReqReady = 1'b1;
  logic [31:0] imemReqAddr;
  logic        imemRespValid = 1'b0;
  logic [31:0] imemRespData = 32'h0;
  logic        stallOnDecode = 1'b0;
  logic        jumpEnabled = 1'b0;
  logic [31:0] jumpValue = 32'h0;
  logic        fetchValid;
  logic [31:0] fetchProgramCounter;
  logic [31:0] fetchInstruction;

  always #5 clock = ~clock;

  pipeline_fetch_unit dut (
    .clock               (clock),
    .reset               (reset),
    .imemReqValid        (imemReqValid),
    .imemReqReady        (imemReqReady),
    .imemReqAddr         (imemReqAddr),
    .imemRespValid       (imemRespValid),
    .imemRespData        (imemRespData),
    .stallOnDecode       (stallOnDecode),
    .jumpEnabled         (jumpEnabled),
    .jumpValue           (jumpValue),
    .fetchValid          (fetchValid),
    .fetchProgramCounter (fetchProgramCounter),
    .fetchInstruction    (fetchInstruction)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    int          due;
  } mreq_t;

  mreq_t mq[$];
  int    cyc = 0;
  int    lat = 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic cyc_begin();
    @(negedge clock);
    cyc++;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imemRespValid = 1'b1;
      imemRespData  = mem_word(mq[0].a);
      void'(mq.pop_front());
    end else begin
      imemRespValid = 1'b0;
      imemRespData  = 32'h0;
    end
  endtask

  task automatic cyc_end();
    mreq_t r;
    #1;
    if (imemReqValid && imemReqReady) begin
      r.a   = imemReqAddr;
      r.due = cyc + lat;
      mq.push_back(r);
    end
  endtask

  task automatic run(input string nm, input int l, input logic [31:0] spc,
                     input int nst, input logic [31:0] jpc,
                     input logic [31:0] tgt, input int ngap, input int nexp,
                     input bit keep_q, input int pre_gap);
    logic [31:0] exq[$];
    logic [31:0] p;
    logic [31:0] prev_addr;
    bit          br, jumped, held_prev;
    int          idx, it, first_v, stc, gap;

    lat = l;
    if (!keep_q) mq.delete();
    p  = 32'h3000;
    br = 1'b0;
    for (int i = 0; i < nexp; i++) begin
      exq.push_back(p);
      if (jpc != 0 && p == jpc) br = 1'b1;
      if (br && p == jpc + 32'd4) begin
        p  = tgt;
        br = 1'b0;
      end else begin
        p = p + 32'd4;
      end
    end

    reset = 1'b1; stallOnDecode = 1'b0; jumpEnabled = 1'b0;
    jumpValue = 32'h0; imemReqReady = 1'b1;
    repeat (2) begin cyc_begin(); cyc_end(); end
    cyc_begin();
    check({nm, ":rst_req"}, 32'(imemReqValid), 32'h0);
    check({nm, ":rst_vld"}, 32'(fetchValid), 32'h0);
    check({nm, ":rst_ins"}, fetchInstruction, 32'h0);
    check({nm, ":rst_pc"}, fetchProgramCounter, 32'h3000);
    reset = 1'b0;
    imemReqReady = (pre_gap == 0);
    gap = (pre_gap > 0) ? pre_gap - 1 : 0;
    cyc_end();
    held_prev = imemReqValid && !imemReqReady;
    prev_addr = imemReqAddr;

    idx = 0; it = 0; first_v = -1; stc = nst; jumped = 1'b0;
    while (idx < nexp && it < 300) begin
      cyc_begin();
      it++;
      if (held_prev) check({nm, ":hold"}, imemReqAddr, prev_addr);
      imemReqReady = (gap == 0);
      if (gap > 0) gap--;
      if (pre_gap > 0 && it == pre_gap) begin
        check({nm, ":stale_vld"}, 32'(fetchValid), 32'h0);
        check({nm, ":stale_addr"}, imemReqAddr, 32'h3000);
      end
      stallOnDecode = 1'b0;
      jumpEnabled   = 1'b0;
      if (fetchValid && first_v < 0) begin
        first_v = it;
        if (!keep_q && pre_gap == 0)
          check({nm, ":lat"}, 32'(first_v), 32'(l + 1));
      end
      if (fetchValid) begin
        if (fetchProgramCounter == spc && stc > 0) begin
          stallOnDecode = 1'b1;
          stc--;
          check({nm, ":stall_ins"}, fetchInstruction, mem_word(spc));
          if (stc == 0 && nst >= 3)
            check({nm, ":stall_req"}, 32'(imemReqValid), 32'h0);
        end else if (jpc != 0 && fetchProgramCounter == jpc && !jumped) begin
          jumpEnabled = 1'b1;
          jumpValue   = tgt;
          jumped      = 1'b1;
          if (ngap > 0) begin
            imemReqReady = 1'b0;
            gap = ngap - 1;
          end
        end
        if (!stallOnDecode) begin
          check({nm, ":pc"}, fetchProgramCounter, exq[idx]);
          check({nm, ":ins"}, fetchInstruction, mem_word(exq[idx]));
          idx++;
        end
      end
      cyc_end();
      held_prev = imemReqValid && !imemReqReady;
      prev_addr = imemReqAddr;
    end
    check({nm, ":done"}, 32'(idx), 32'(nexp));
    stallOnDecode = 1'b0;
    jumpEnabled   = 1'b0;
    imemReqReady  = 1'b1;
  endtask

  initial begin
    run("seq",      1, 32'h0,    0, 32'h0,    32'h0,    0, 6, 1'b0, 0);
    run("stall",    1, 32'h3008, 5, 32'h0,    32'h0,    0, 8, 1'b0, 0);
    run("jmp_buf",  1, 32'h3008, 3, 32'h3008, 32'h3400, 0, 7, 1'b0, 0);
    run("jmp_lat4", 4, 32'h0,    0, 32'h3008, 32'h3400, 0, 7, 1'b0, 0);
    run("jmp_wait", 4, 32'h0,    0, 32'h3004, 32'h3400, 0, 6, 1'b0, 0);
    run("jmp_d4",   4, 32'h0,    0, 32'h3004, 32'h300C, 0, 6, 1'b0, 0);
    run("jmp_rdy",  1, 32'h0,    0, 32'h3008, 32'h3400, 3, 7, 1'b0, 0);
    run("pre_rst",  4, 32'h0,    0, 32'h0,    32'h0,    0, 0, 1'b0, 0);
    cyc_begin();
    cyc_end();
    run("post_rst", 4, 32'h0,    0, 32'h0,    32'h0,    0, 5, 1'b1, 6);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
